// File: rtl/kypd_scan_ctrl.sv
// Matrix keypad scanner: one-hot active-low column drive, synchronised row sampling,
// frame-level debounce with multi-key rejection, and a valid/ready press-event output.
module kypd_scan_ctrl #(
  parameter int unsigned NUM_COLS = 4,
  parameter int unsigned NUM_ROWS = 4,
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  output logic [NUM_COLS-1:0] o_col,
  input  logic [NUM_ROWS-1:0] i_row,
  output logic [7:0]          o_key_code,
  output logic                o_key_valid,
  input  logic                i_key_ready,
  output logic                o_key_down,
  output logic                o_overflow
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned ColW = $clog2(NUM_COLS);
  localparam int unsigned RowW = $clog2(NUM_ROWS);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [ColW-1:0] ColLast = ColW'(NUM_COLS - 1);
  localparam logic [3:0]      DebCnt  = 4'(DEBOUNCE);
  localparam bit              DebOne  = (DEBOUNCE == 1);

  typedef enum logic [1:0] {StIdle, StPressChk, StHeld, StRelChk} state_e;

  logic [NUM_ROWS-1:0] r_row_meta, r_row_sync;
  logic [DivW-1:0]     r_div;
  logic [ColW-1:0]     r_col_idx;
  logic [1:0]          r_hits;
  logic [7:0]          r_min;
  logic                r_eval;
  state_e              r_state;
  logic [3:0]          r_cnt;
  logic [7:0]          r_cand;
  logic                r_accept;
  logic [7:0]          r_acc_code;
  logic                r_key_down;
  logic [7:0]          r_key_code;
  logic                r_key_valid;
  logic                r_overflow;

  logic                w_dwell_end;
  logic [1:0]          w_col_hits;
  logic [RowW-1:0]     w_col_row;
  logic [7:0]          w_col_idx;
  logic [2:0]          w_sum;
  logic                w_none, w_single;

  // Two-flop synchroniser for the asynchronous rows; idle level is all ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row_meta <= '1;
      r_row_sync <= '1;
    end else begin
      r_row_meta <= i_row;
      r_row_sync <= r_row_meta;
    end
  end

  assign w_dwell_end = (r_div == DivLast);

  // Dwell counter and column pointer; the column advances right after its sample.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div     <= '0;
      r_col_idx <= '0;
    end else if (w_dwell_end) begin
      r_div     <= '0;
      r_col_idx <= (r_col_idx == ColLast) ? '0 : r_col_idx + ColW'(1);
    end else begin
      r_div <= r_div + DivW'(1);
    end
  end

  // Active-low one-hot column drive decoded from the pointer.
  always_comb begin
    o_col = '1;
    for (int unsigned c = 0; c < NUM_COLS; c++) o_col[c] = (r_col_idx != ColW'(c));
  end

  // Hits in the current column (saturating at 2) and the lowest pressed row.
  always_comb begin
    w_col_hits = 2'd0;
    w_col_row  = '0;
    for (int r = int'(NUM_ROWS) - 1; r >= 0; r--) begin
      if (!r_row_sync[r]) begin
        w_col_row = RowW'(r);
        if (w_col_hits != 2'd2) w_col_hits = w_col_hits + 2'd1;
      end
    end
  end

  assign w_col_idx = 8'(w_col_row) * 8'(NUM_COLS) + 8'(r_col_idx);
  assign w_sum     = {1'b0, r_hits} + {1'b0, w_col_hits};

  // Frame accumulators; column 0 restarts them so no explicit clear is needed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hits <= 2'd0;
      r_min  <= 8'd0;
      r_eval <= 1'b0;
    end else begin
      r_eval <= w_dwell_end && (r_col_idx == ColLast);
      if (w_dwell_end) begin
        if (r_col_idx == '0) begin
          r_hits <= w_col_hits;
          r_min  <= w_col_idx;
        end else begin
          r_hits <= (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
          if (w_col_hits != 2'd0 && (r_hits == 2'd0 || w_col_idx < r_min)) r_min <= w_col_idx;
        end
      end
    end
  end

  assign w_none   = (r_hits == 2'd0);
  assign w_single = (r_hits == 2'd1);

  // Debounce FSM, stepped once per frame evaluation; r_accept is a one-cycle event.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_cnt      <= 4'd0;
      r_cand     <= 8'd0;
      r_accept   <= 1'b0;
      r_acc_code <= 8'd0;
      r_key_down <= 1'b0;
    end else begin
      r_accept <= 1'b0;
      if (r_eval) begin
        unique case (r_state)
          StIdle: begin
            if (w_single) begin
              r_cand <= r_min;
              r_cnt  <= 4'd1;
              if (DebOne) begin
                r_accept   <= 1'b1;
                r_acc_code <= r_min;
                r_key_down <= 1'b1;
                r_state    <= StHeld;
              end else begin
                r_state <= StPressChk;
              end
            end
          end
          StPressChk: begin
            if (!w_single) begin
              r_state <= StIdle;
            end else if (r_min != r_cand) begin
              r_cand <= r_min;
              r_cnt  <= 4'd1;
            end else if (r_cnt + 4'd1 == DebCnt) begin
              r_cnt      <= r_cnt + 4'd1;
              r_accept   <= 1'b1;
              r_acc_code <= r_cand;
              r_key_down <= 1'b1;
              r_state    <= StHeld;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          StHeld: begin
            if (w_none) begin
              r_cnt <= 4'd1;
              if (DebOne) begin
                r_key_down <= 1'b0;
                r_state    <= StIdle;
              end else begin
                r_state <= StRelChk;
              end
            end
          end
          StRelChk: begin
            if (!w_none) begin
              r_state <= StHeld;
            end else if (r_cnt + 4'd1 == DebCnt) begin
              r_cnt      <= r_cnt + 4'd1;
              r_key_down <= 1'b0;
              r_state    <= StIdle;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  // Event register: load on accept, drop with sticky overflow when still unconsumed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_key_code  <= 8'd0;
      r_key_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (r_accept) begin
      if (!r_key_valid || i_key_ready) begin
        r_key_code  <= r_acc_code;
        r_key_valid <= 1'b1;
      end else begin
        r_overflow <= 1'b1;
      end
    end else if (r_key_valid && i_key_ready) begin
      r_key_valid <= 1'b0;
    end
  end

  assign o_key_code  = r_key_code;
  assign o_key_valid = r_key_valid;
  assign o_key_down  = r_key_down;
  assign o_overflow  = r_overflow;

endmodule
